// File: rtl/uart_tx_pkg.sv
// -----------------------------------------------------------------------------
// uart_tx_pkg
// Shared definitions for the memory-mapped UART transmitter:
//   - register offsets decoded on mem_addr[3:2]
//   - bit positions inside the STATUS register
//   - shifter FSM state encoding
//   - eff_div(): converts a programmed divider into clocks per bit
// No ports (package).
// -----------------------------------------------------------------------------
package uart_tx_pkg;

    // Register offsets, word index = mem_addr[3:2]
    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_RSVD   = 2'd3;

    // STATUS register bit indices
    localparam int STAT_FULL  = 0;
    localparam int STAT_EMPTY = 1;
    localparam int STAT_BUSY  = 2;

    // Number of data bits in an 8N1 frame
    localparam int DATA_BITS = 8;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_t;

    // A programmed divider of 0 still has to hold each bit for one clock.
    function automatic logic [15:0] eff_div(input logic [15:0] d);
        return (d == 16'd0) ? 16'd1 : d;
    endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Single-clock synchronous FIFO holding bytes waiting to be serialised.
// Push into a full FIFO and pop from an empty FIFO are ignored. A push and a
// pop in the same cycle leave the count unchanged and keep data order.
// Ports:
//   clk, resetn          clock, synchronous active-low reset
//   push, push_data      write one entry
//   pop, pop_data        pop_data shows the oldest entry; pop removes it
//   full, empty, count   occupancy
// DEPTH must be a power of 2 and at least 2.
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     resetn,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // NOTE: sequential state is assigned with <= so every register samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            if (do_push && !do_pop)      count <= count + 1'b1;
            else if (do_pop && !do_push) count <= count - 1'b1;
        end
    end

    // NOTE: the storage array is deliberately not reset; the pointers and
    // count define validity, and a reset-free array maps onto plain RAM.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (count == (AW + 1)'(DEPTH));
    assign empty    = (count == '0);

endmodule

// File: rtl/uart_tx_periph.sv
// -----------------------------------------------------------------------------
// uart_tx_periph
// PicoRV32 native-bus UART transmitter (8N1) with a TX FIFO.
// Registers (word index mem_addr[3:2]):
//   0 DATA   write: push mem_wdata[7:0] when mem_wstrb[0]; read: 0
//            (a write with a full FIFO is stalled until an entry frees up)
//   1 STATUS read: {29'b0, tx_busy, fifo_empty, fifo_full}; writes ignored
//   2 DIV    clocks per bit (0 behaves as 1); byte lanes 0/1 writable
//   3 reserved, reads 0, writes ignored
// Ports:
//   clk, resetn                    clock, synchronous active-low reset
//   mem_valid/addr/wdata/wstrb     bus request (wstrb==0 is a read)
//   mem_ready                      registered one-cycle acknowledge
//   mem_rdata                      read data, valid with mem_ready
//   uart_tx                        registered serial output, idle high
//   tx_busy                        FIFO non-empty or frame in flight
// -----------------------------------------------------------------------------
module uart_tx_periph
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0200_0000,
    parameter int          FIFO_DEPTH  = 8,
    parameter logic [15:0] DEFAULT_DIV = 16'd104
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        mem_valid,
    input  logic [31:0] mem_addr,
    input  logic [31:0] mem_wdata,
    input  logic [3:0]  mem_wstrb,
    output logic        mem_ready,
    output logic [31:0] mem_rdata,
    output logic        uart_tx,
    output logic        tx_busy
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    // ---------------- bus decode ----------------
    logic        sel;
    logic [1:0]  reg_sel;
    logic        is_write;
    logic        data_write;
    logic        accept;
    logic        push;
    logic [31:0] rdata_next;
    logic [15:0] div;

    // ---------------- FIFO ----------------
    logic          pop;
    logic [7:0]    fifo_data;
    logic          fifo_full;
    logic          fifo_empty;
    logic [CW-1:0] fifo_count;

    // ---------------- shifter ----------------
    tx_state_t   state, state_next;
    logic [2:0]  bit_idx, bit_next;
    logic [15:0] clk_cnt, cnt_next;
    logic [7:0]  shreg, sh_next;
    logic [15:0] frame_div, fdiv_next;
    logic        tx_q, tx_next;
    logic        bit_end;

    // Address bits and lanes that play no part in decode or storage.
    logic unused_bits;
    assign unused_bits = ^{mem_addr[23:4], mem_addr[1:0], mem_wdata[31:16], mem_wstrb[3:2]};

    assign sel        = mem_valid && (mem_addr[31:24] == BASE_ADDR[31:24]);
    assign reg_sel    = mem_addr[3:2];
    assign is_write   = |mem_wstrb;
    assign data_write = is_write && (reg_sel == REG_DATA);
    // mem_ready high blocks a second accept of the same request; a DATA
    // write meeting a full FIFO simply waits here until a pop frees space.
    assign accept     = sel && !mem_ready && !(data_write && fifo_full);
    assign push       = accept && data_write && mem_wstrb[0];

    assign tx_busy = (fifo_count != '0) || (state != ST_IDLE);
    assign uart_tx = tx_q;

    // NOTE: every variable written here gets a default first, so no path
    // through the block leaves it unassigned and no latch is inferred.
    always_comb begin
        rdata_next = '0;
        case (reg_sel)
            REG_STATUS: begin
                rdata_next[STAT_BUSY]  = tx_busy;
                rdata_next[STAT_EMPTY] = fifo_empty;
                rdata_next[STAT_FULL]  = fifo_full;
            end
            REG_DIV:    rdata_next = {16'b0, div};
            default:    rdata_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            mem_ready <= 1'b0;
            mem_rdata <= '0;
            div       <= DEFAULT_DIV;
        end else begin
            mem_ready <= accept;
            if (accept && !is_write) mem_rdata <= rdata_next;
            if (accept && is_write && (reg_sel == REG_DIV)) begin
                if (mem_wstrb[0]) div[7:0]  <= mem_wdata[7:0];
                if (mem_wstrb[1]) div[15:8] <= mem_wdata[15:8];
            end
        end
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk       (clk),
        .resetn    (resetn),
        .push      (push),
        .push_data (mem_wdata[7:0]),
        .pop       (pop),
        .pop_data  (fifo_data),
        .full      (fifo_full),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // ---------------- shifter FSM ----------------
    assign bit_end = (clk_cnt == frame_div - 16'd1);

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_IDLE;
            bit_idx   <= '0;
            clk_cnt   <= '0;
            shreg     <= '0;
            frame_div <= 16'd1;
            tx_q      <= 1'b1;
        end else begin
            state     <= state_next;
            bit_idx   <= bit_next;
            clk_cnt   <= cnt_next;
            shreg     <= sh_next;
            frame_div <= fdiv_next;
            tx_q      <= tx_next;
        end
    end

    always_comb begin
        state_next = state;
        bit_next   = bit_idx;
        cnt_next   = clk_cnt;
        sh_next    = shreg;
        fdiv_next  = frame_div;
        pop        = 1'b0;

        unique case (state)
            ST_IDLE: begin
                if (!fifo_empty) begin
                    pop        = 1'b1;
                    state_next = ST_START;
                    sh_next    = fifo_data;
                    fdiv_next  = eff_div(div);
                    cnt_next   = '0;
                end
            end
            ST_START: begin
                if (bit_end) begin
                    state_next = ST_DATA;
                    cnt_next   = '0;
                    bit_next   = '0;
                end else begin
                    cnt_next = clk_cnt + 16'd1;
                end
            end
            ST_DATA: begin
                if (bit_end) begin
                    cnt_next = '0;
                    if (bit_idx == 3'(DATA_BITS - 1)) begin
                        state_next = ST_STOP;
                    end else begin
                        bit_next = bit_idx + 3'd1;
                        sh_next  = {1'b0, shreg[7:1]};
                    end
                end else begin
                    cnt_next = clk_cnt + 16'd1;
                end
            end
            ST_STOP: begin
                if (bit_end) begin
                    cnt_next = '0;
                    // Chain straight into the next start bit: no idle gap.
                    if (!fifo_empty) begin
                        pop        = 1'b1;
                        state_next = ST_START;
                        sh_next    = fifo_data;
                        fdiv_next  = eff_div(div);
                    end else begin
                        state_next = ST_IDLE;
                    end
                end else begin
                    cnt_next = clk_cnt + 16'd1;
                end
            end
            default: state_next = ST_IDLE;
        endcase

        // Line level follows the state being entered, so uart_tx is a flop.
        case (state_next)
            ST_START: tx_next = 1'b0;
            ST_DATA:  tx_next = sh_next[0];
            default:  tx_next = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_uart_tx_periph.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_periph
// Directed self-checking bench for uart_tx_periph. Inputs change on the
// falling edge; outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_uart_tx_periph;

    localparam logic [31:0] BASE     = 32'h0200_0000;
    localparam logic [31:0] A_DATA   = BASE + 32'h0;
    localparam logic [31:0] A_STATUS = BASE + 32'h4;
    localparam logic [31:0] A_DIV    = BASE + 32'h8;
    localparam logic [31:0] A_RSVD   = BASE + 32'hC;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic        uart_tx;
    logic        tx_busy;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] b2b_bytes [10] = '{8'h55, 8'hA3, 8'h0F, 8'hF0, 8'h01,
                                   8'h80, 8'h3C, 8'hC3, 8'h7E, 8'h96};

    always #5 clk = ~clk;

    uart_tx_periph #(
        .BASE_ADDR   (BASE),
        .FIFO_DEPTH  (8),
        .DEFAULT_DIV (16'd104)
    ) dut (
        .clk       (clk),
        .resetn    (resetn),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_wstrb (mem_wstrb),
        .mem_ready (mem_ready),
        .mem_rdata (mem_rdata),
        .uart_tx   (uart_tx),
        .tx_busy   (tx_busy)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // Expected line level for bit slot 0..9 of an 8N1 frame carrying b.
    function automatic logic exp_bit(input logic [7:0] b, input int slot);
        if (slot == 0) return 1'b0;
        if (slot == 9) return 1'b1;
        return b[slot-1];
    endfunction

    task automatic bus_write(input logic [31:0] a, input logic [31:0] d,
                             input logic [3:0] s, output int waits);
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        waits = 0;
        do begin
            @(posedge clk); #1;
            waits++;
        end while (mem_ready !== 1'b1 && waits < 3000);
        check($sformatf("wr_ack_%08h", a), mem_ready, 1);
        mem_valid = 1'b0; mem_wstrb = 4'h0;
    endtask

    task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
        int waits = 0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wstrb = 4'h0;
        do begin
            @(posedge clk); #1;
            waits++;
        end while (mem_ready !== 1'b1 && waits < 20);
        check($sformatf("rd_ack_%08h", a), mem_ready, 1);
        d = mem_rdata;
        mem_valid = 1'b0;
    endtask

    // Holds a request for 20 cycles and counts acknowledges seen.
    task automatic unsel_access(input logic [31:0] a, input logic [31:0] d,
                                input logic [3:0] s, output int readys);
        readys = 0;
        @(negedge clk);
        mem_valid = 1'b1; mem_addr = a; mem_wdata = d; mem_wstrb = s;
        repeat (20) begin
            @(posedge clk); #1;
            if (mem_ready === 1'b1) readys++;
        end
        mem_valid = 1'b0; mem_wstrb = 4'h0;
    endtask

    task automatic wait_start(input string tag);
        int steps = 0;
        while (uart_tx !== 1'b0 && steps < 50) begin
            @(posedge clk); #1;
            steps++;
        end
        check(tag, uart_tx, 0);
    endtask

    // Called on the first start-bit sample; returns one cycle past the frame.
    task automatic capture_frame(input logic [7:0] b, input int div,
                                 output int bad, output logic busy_last);
        bad = 0;
        busy_last = 1'b0;
        for (int c = 0; c < 10 * div; c++) begin
            if (uart_tx !== exp_bit(b, c / div)) bad++;
            busy_last = tx_busy;
            @(posedge clk); #1;
        end
    endtask

    initial begin
        logic [31:0] rd;
        int          w;
        int          bad;
        int          lows;
        logic        busy;

        resetn = 1'b0; mem_valid = 1'b0; mem_addr = '0; mem_wdata = '0; mem_wstrb = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_uart_tx",   uart_tx,   1);
        check("rst_mem_ready", mem_ready, 0);
        check("rst_mem_rdata", mem_rdata, 0);
        check("rst_tx_busy",   tx_busy,   0);
        @(negedge clk) resetn = 1'b1;

        // Reset values of the registers
        bus_read(A_STATUS, rd); check("status_after_reset", rd, 32'h0000_0002);
        bus_read(A_DIV, rd);    check("div_after_reset",    rd, 32'h0000_0068);

        // Register map corner cases
        bus_read(A_DATA, rd); check("data_read_zero", rd, 0);
        bus_read(A_RSVD, rd); check("rsvd_read_zero", rd, 0);
        bus_write(A_STATUS, 32'hFFFF_FFFF, 4'hF, w);
        bus_write(A_RSVD,   32'hFFFF_FFFF, 4'hF, w);
        bus_write(A_DATA,   32'h0000_00AA, 4'b1110, w);
        bus_read(A_STATUS, rd); check("status_after_ignored_writes", rd, 32'h0000_0002);
        bus_write(A_DIV, 32'hABCD_12EE, 4'b0010, w);
        bus_read(A_DIV, rd); check("div_lane1_only", rd, 32'h0000_1268);
        bus_write(A_DIV, 32'h5555_5555, 4'b1100, w);
        bus_read(A_DIV, rd); check("div_upper_lanes_ignored", rd, 32'h0000_1268);

        // DIV=4, byte 0x41: 40-clock frame
        bus_write(A_DIV, 32'h0000_0004, 4'b0011, w);
        bus_write(A_DATA, 32'h0000_0041, 4'b0001, w);
        wait_start("f41_start");
        capture_frame(8'h41, 4, bad, busy);
        check("f41_bits",         bad,     0);
        check("f41_busy_in_stop", busy,    1);
        check("f41_busy_after",   tx_busy, 0);
        check("f41_idle_high",    uart_tx, 1);

        // DIV=0 behaves as 1 clock per bit
        bus_write(A_DIV, 32'h0000_0000, 4'b0011, w);
        bus_read(A_DIV, rd); check("div_zero_readback", rd, 0);
        bus_write(A_DATA, 32'h0000_00FF, 4'b0001, w);
        wait_start("fff_start");
        capture_frame(8'hFF, 1, bad, busy);
        check("fff_bits",         bad,     0);
        check("fff_busy_in_stop", busy,    1);
        check("fff_busy_after",   tx_busy, 0);

        // DIV=100, ten back-to-back writes: 10th stalls, frames chain gap-free
        bus_write(A_DIV, 32'h0000_0064, 4'b0011, w);
        fork
            begin
                int waits [10];
                for (int i = 0; i < 10; i++) begin
                    bus_write(A_DATA, {24'h0, b2b_bytes[i]}, 4'b0001, w);
                    waits[i] = w;
                end
                for (int i = 0; i < 9; i++)
                    check($sformatf("b2b_no_stall_%0d", i), 32'(waits[i] <= 2), 1);
                check("b2b_tenth_stall_len", 32'(waits[9] >= 980 && waits[9] <= 990), 1);
            end
            begin
                int fbad;
                logic fbusy;
                wait_start("b2b_start");
                for (int f = 0; f < 10; f++) begin
                    capture_frame(b2b_bytes[f], 100, fbad, fbusy);
                    check($sformatf("b2b_frame_%0d_bits", f), fbad, 0);
                end
                check("b2b_busy_after", tx_busy, 0);
            end
        join

        // Reset in the middle of a data bit, with another byte queued
        bus_write(A_DIV, 32'h0000_0008, 4'b0011, w);
        bus_write(A_DATA, 32'h0000_005A, 4'b0001, w);
        wait_start("rst_frame_start");
        bus_write(A_DATA, 32'h0000_0033, 4'b0001, w);
        repeat (26) begin @(posedge clk); #1; end
        check("pre_reset_data_bit2_low", uart_tx, 0);
        check("pre_reset_busy",          tx_busy, 1);
        @(negedge clk) resetn = 1'b0;
        @(posedge clk); #1;
        check("reset_tx_high_first_cycle", uart_tx,   1);
        check("reset_mem_ready_low",       mem_ready, 0);
        @(negedge clk) resetn = 1'b1;
        @(posedge clk); #1;
        check("post_reset_tx_high", uart_tx, 1);
        check("post_reset_idle",    tx_busy, 0);
        bus_read(A_STATUS, rd); check("post_reset_status", rd, 32'h0000_0002);
        bus_read(A_DIV, rd);    check("post_reset_div",    rd, 32'h0000_0068);
        lows = 0;
        repeat (200) begin
            @(posedge clk); #1;
            if (uart_tx !== 1'b1) lows++;
        end
        check("post_reset_no_edges", lows, 0);

        // Accesses outside the decode region
        unsel_access(32'h0000_1000, 32'h0000_0000, 4'h0, w);
        check("unsel_read_no_ready",  w, 0);
        check("unsel_rdata_held",     mem_rdata, 32'h0000_0068);
        unsel_access(32'h0000_1000, 32'h0000_0055, 4'hF, w);
        check("unsel_write_no_ready", w, 0);
        unsel_access(32'h0000_1008, 32'h0000_0005, 4'hF, w);
        check("unsel_div_write_no_ready", w, 0);
        check("unsel_tx_idle",   uart_tx, 1);
        check("unsel_busy_low",  tx_busy, 0);
        bus_read(A_STATUS, rd); check("unsel_status_unchanged", rd, 32'h0000_0002);
        bus_read(A_DIV, rd);    check("unsel_div_unchanged",    rd, 32'h0000_0068);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_tx_periph.md
UART_TX_PERIPH -- requirements
Module: uart_tx_periph

Interface
REQ-001 SHALL have parameter BASE_ADDR, 32'h0200_0000, base of the peripheral's 16 MB decode region; it is matched on mem_addr[31:24].
REQ-002 SHALL have parameter FIFO_DEPTH, 8, TX FIFO entries; it must be a power of 2 and at least 2.
REQ-003 SHALL have parameter DEFAULT_DIV, 16'd104, reset value of the clocks-per-bit divider.
REQ-004 SHALL have port clk  input  1  clock; all logic on posedge.
REQ-005 SHALL have port resetn  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port mem_valid  input  1  PicoRV32 native bus request.
REQ-007 SHALL have port mem_addr  input  32  byte address.
REQ-008 SHALL have port mem_wdata  input  32  write data.
REQ-009 SHALL have port mem_wstrb  input  4  byte write strobes; 0 means read.
REQ-010 SHALL have port mem_ready  output  1  registered one-cycle acknowledge; the system ORs it with the RAM ready.
REQ-011 SHALL have port mem_rdata  output  32  read data, valid when mem_ready=1.
REQ-012 SHALL have port uart_tx  output  1  8N1 serial line, idle high.
REQ-013 SHALL have port tx_busy  output  1  high while the FIFO is not empty or a frame is in flight.

Function
REQ-014 SHALL select an access only when mem_valid=1 and mem_addr[31:24]=BASE_ADDR[31:24].
REQ-015 SHALL decode registers on mem_addr[3:2] as follows: 0 DATA, 1 STATUS, 2 DIV, 3 reserved.
REQ-016 SHALL accept a selected access in a cycle where mem_ready=0, except a DATA write while the FIFO is full.
REQ-017 SHALL assert mem_ready for exactly one cycle, in the cycle after acceptance.
REQ-018 SHALL hold mem_ready low for a DATA write with a full FIFO (stall) until a pop frees an entry, then accept the write.
REQ-019 SHALL push mem_wdata[7:0] on a DATA write with mem_wstrb[0]=1; a DATA write with mem_wstrb[0]=0 is acked with no push.
REQ-020 SHALL return STATUS as {29'b0, tx_busy, fifo_empty, fifo_full} in bits [2:0].
REQ-021 SHALL return DIV as {16'b0, div}.
REQ-022 SHALL return 0 for reads of DATA and of the reserved register.
REQ-023 SHALL ignore writes to STATUS and to the reserved register, and ack them.
REQ-024 SHALL write DIV per byte lane using mem_wstrb[1:0]; mem_wstrb[3:2] are ignored.
REQ-025 SHALL treat a written DIV value of 0 as 1 clock per bit.
REQ-026 SHALL use a shifter FSM with states IDLE, START, DATA, STOP.
REQ-027 SHALL transition IDLE->START when the FIFO is not empty; the pop and the latch of byte and div happen in the same cycle.
REQ-028 SHALL drive each bit for exactly max(div,1) clocks in order: start 0, data LSB first (8 bits), stop 1; a frame is 10*max(div,1) clocks.
REQ-029 SHALL transition STOP->START directly when the FIFO is not empty at the end of STOP, giving no idle gap between frames; otherwise STOP->IDLE.
REQ-030 SHALL use the div latched at frame start for the whole frame; a DIV write mid-frame affects only the next frame.
REQ-031 SHALL, on a push and pop in the same cycle, leave the count unchanged and preserve data order.
REQ-032 SHALL register uart_tx so that it is glitch-free.
REQ-033 SHALL leave mem_ready=0 and mem_rdata unchanged for any unselected address.

Reset
REQ-034 SHALL, when resetn=0 at a posedge, set uart_tx=1, mem_ready=0, mem_rdata=0, FIFO empty, div=DEFAULT_DIV and FSM=IDLE.
REQ-035 SHALL abort a frame on reset mid-frame, with uart_tx high in the first cycle after reset and no partial byte resumed.
REQ-036 SHALL discard a stalled write on reset; the bus master is reset concurrently.

Structure
REQ-037 SHALL place the register offsets, STATUS bit indices and FSM state encoding in shared package uart_tx_pkg.
REQ-038 SHALL implement the FIFO as sub-module uart_tx_fifo: synchronous, single clock, with push, pop, full, empty and count.
REQ-039 SHALL contain no combinational path from mem_valid to mem_ready.

Verification
REQ-040 SHALL verify: after reset, read STATUS -> 0x0000_0002, read DIV -> 0x0000_0068.
REQ-041 SHALL verify: DIV=4, write 0x41 to DATA -> uart_tx low 4 clk, then 1,0,0,0,0,0,1,0 at 4 clk each, then high 4 clk; total 40 clk; tx_busy falls after the stop bit.
REQ-042 SHALL verify: DIV=0, write 0xFF -> 10-clock frame: one 0 clock then 9 high clocks.
REQ-043 SHALL verify: DIV=100, 10 back-to-back DATA writes -> first 9 acked without stall; 10th stalls until the first frame ends (~1000 clk); all 10 bytes transmitted in order with no inter-frame gap.
REQ-044 SHALL verify: resetn low mid-data-bit -> uart_tx=1 the next cycle, STATUS=0x2, no further edges.
REQ-045 SHALL verify: read or write at 0x0000_1000 -> mem_ready never asserted, and state unchanged.
